// File: rtl/pc_fetch_sequencer.sv
// Fetch controller: computes next_pc for the pc register, runs the imem request/ack
// handshake and holds one fetched instruction for decode.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0100_0000,
    parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] current_pc,
    output logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        trap,
    input  logic        halt_req,
    output logic        halted,
    output logic        misalign_err,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_FLUSH,
        S_ISSUE,
        S_HALT
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nxt;
    logic        waiting;
    logic        misaligned;
    logic        timeout;
    logic        trap_take;
    logic        redir;
    logic        load_instr;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign waiting    = (state == S_FETCH) || (state == S_FLUSH);
    assign misaligned = redirect_valid && (redirect_target[1:0] != 2'b00);
    // The cycle on which the counter would reach ACK_TIMEOUT is the timeout cycle.
    assign timeout    = waiting && !imem_ack && (cnt >= CNT_LAST);
    assign trap_take  = trap || misaligned || timeout;
    assign redir      = trap_take || redirect_valid;

    assign imem_req     = (state == S_FETCH);
    assign imem_addr    = current_pc;
    assign instr_valid  = (state == S_ISSUE);
    assign halted       = (state == S_HALT);
    assign misalign_err = !reset && misaligned;
    assign timeout_err  = timeout;

    always_comb begin
        next_pc = current_pc;
        if (reset) begin
            next_pc = RESET_PC;
        end else if (trap_take) begin
            next_pc = TRAP_VEC;
        end else if (redirect_valid) begin
            next_pc = redirect_target;
        end else if ((state == S_FETCH) && imem_ack) begin
            next_pc = current_pc + 32'd4;
        end
    end

    // Counter clears by default; only an outstanding wait keeps counting.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = '0;
        load_instr = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    if (!redir) begin
                        load_instr = 1'b1;
                        state_nxt  = S_ISSUE;
                    end
                end else if (timeout) begin
                    state_nxt = S_FETCH;
                end else if (redir) begin
                    state_nxt = S_FLUSH;
                end else begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            S_FLUSH: begin
                if (imem_ack || timeout) begin
                    state_nxt = S_FETCH;
                end else begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            S_ISSUE: begin
                if (redir) begin
                    state_nxt = S_FETCH;
                end else if (instr_ready) begin
                    state_nxt = halt_req ? S_HALT : S_FETCH;
                end
            end
            S_HALT: begin
                if (!halt_req) begin
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            instr    <= '0;
            instr_pc <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load_instr) begin
                instr    <= imem_rdata;
                instr_pc <= current_pc;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: models the pc register and imem, scoreboards issued instructions.
module tb_pc_fetch_sequencer;
    localparam logic [31:0] RESET_PC    = 32'h0100_0000;
    localparam logic [31:0] TRAP_VEC    = 32'h0000_0100;
    localparam int          ACK_TIMEOUT = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] current_pc;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        trap = 1'b0;
    logic        halt_req = 1'b0;
    logic        halted;
    logic        misalign_err;
    logic        timeout_err;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;

    pc_fetch_sequencer #(
        .RESET_PC(RESET_PC),
        .TRAP_VEC(TRAP_VEC),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .current_pc(current_pc),
        .next_pc(next_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .trap(trap),
        .halt_req(halt_req),
        .halted(halted),
        .misalign_err(misalign_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // pc register the sequencer drives
    always_ff @(posedge clk or posedge reset) begin
        if (reset) current_pc <= RESET_PC;
        else       current_pc <= next_pc;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_wait: imem_req=%b after 40 cycles, expected 1", imem_req);
        end
    endtask

    task automatic mem_ack(input int delay, input logic [31:0] data, output logic [31:0] addr);
        bit ok;
        wait_req(ok);
        addr = imem_addr;
        repeat (delay) tick();
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = '0;
    endtask

    task automatic get_issue(input logic halt, output logic [31:0] oi, output logic [31:0] opc,
                             output exp_t ex, output int waited);
        waited = 0;
        while (!instr_valid && waited < 20) begin
            tick();
            waited++;
        end
        if (!instr_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_wait: instr_valid=%b after %0d cycles, expected 1", instr_valid, waited);
        end
        oi  = instr;
        opc = instr_pc;
        if (sb.size() == 0) begin
            ex = '0;
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty: issued instr %h with no expectation queued", oi);
        end else begin
            ex = sb.pop_front();
        end
        instr_ready = 1'b1;
        halt_req    = halt;
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic test_reset();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0003;
        trap            = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b, expected 0", imem_req); end
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, expected 0", instr_valid); end
        n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b, expected 0", halted); end
        n_tests++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL rst_misalign: got %b, expected 0", misalign_err); end
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b, expected 0", timeout_err); end
        n_tests++; if (next_pc !== RESET_PC) begin n_fail++; $display("FAIL rst_next_pc: got %h, expected %h", next_pc, RESET_PC); end
        n_tests++; if ({instr, instr_pc} !== 64'd0) begin n_fail++; $display("FAIL rst_instr: got %h/%h, expected 0/0", instr, instr_pc); end
        redirect_valid = 1'b0;
        trap           = 1'b0;
        reset          = 1'b0;
        #1;
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req: got %b, expected 0", imem_req); end
    endtask

    task automatic test_sequential();
        logic [31:0] a, oi, opc, exp_a;
        exp_t ex;
        int w;
        for (int k = 0; k < 3; k++) begin
            exp_a = RESET_PC + 32'(4 * k);
            sb.push_back('{pc: exp_a, data: 32'hC0DE_0000 + 32'(k)});
            mem_ack(1, 32'hC0DE_0000 + 32'(k), a);
            n_tests++; if (a !== exp_a) begin n_fail++; $display("FAIL seq_addr%0d: got %h, expected %h", k, a, exp_a); end
            get_issue(1'b0, oi, opc, ex, w);
            n_tests++; if (w !== 0) begin n_fail++; $display("FAIL seq_latency%0d: got %0d extra cycles, expected 0", k, w); end
            n_tests++; if ({opc, oi} !== {ex.pc, ex.data}) begin n_fail++; $display("FAIL seq_instr%0d: got %h/%h, expected %h/%h", k, opc, oi, ex.pc, ex.data); end
        end
    endtask

    task automatic test_redirect_issue();
        logic [31:0] a, oi, opc;
        exp_t ex;
        sb.push_back('{pc: 32'h0100_000C, data: 32'h1111_2222});
        mem_ack(1, 32'h1111_2222, a);
        n_tests++; if (a !== 32'h0100_000C) begin n_fail++; $display("FAIL ri_addr: got %h, expected 0100000c", a); end
        oi  = instr;
        opc = instr_pc;
        ex  = sb.pop_front();
        instr_ready     = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0100_0040;
        tick();
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        #1;
        n_tests++; if ({opc, oi} !== {ex.pc, ex.data}) begin n_fail++; $display("FAIL ri_instr: got %h/%h, expected %h/%h", opc, oi, ex.pc, ex.data); end
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL ri_consumed_once: instr_valid got %b, expected 0", instr_valid); end
        n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h0100_0040}) begin n_fail++; $display("FAIL ri_next_addr: got req=%b addr=%h, expected req=1 addr=01000040", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_fetch();
        logic [31:0] a, oi, opc;
        exp_t ex;
        int w;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0100_0080;
        tick();
        redirect_valid = 1'b0;
        #1;
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL flush_req: got %b, expected 0", imem_req); end
        tick();
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        #1;
        n_tests++; if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h0100_0080}) begin n_fail++; $display("FAIL flush_refetch: got valid=%b req=%b addr=%h, expected 0/1/01000080", instr_valid, imem_req, imem_addr); end
        sb.push_back('{pc: 32'h0100_0080, data: 32'h3333_4444});
        mem_ack(1, 32'h3333_4444, a);
        get_issue(1'b0, oi, opc, ex, w);
        n_tests++; if ({opc, oi} !== {ex.pc, ex.data}) begin n_fail++; $display("FAIL flush_instr: got %h/%h, expected %h/%h", opc, oi, ex.pc, ex.data); end
        // ack and redirect on the same cycle: data dropped, fetch stays active
        imem_ack        = 1'b1;
        imem_rdata      = 32'hBAD0_BAD0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0100_0100;
        tick();
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        #1;
        n_tests++; if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h0100_0100}) begin n_fail++; $display("FAIL ackredir: got valid=%b req=%b addr=%h, expected 0/1/01000100", instr_valid, imem_req, imem_addr); end
        sb.push_back('{pc: 32'h0100_0100, data: 32'h5555_6666});
        mem_ack(1, 32'h5555_6666, a);
        get_issue(1'b0, oi, opc, ex, w);
        n_tests++; if ({opc, oi} !== {ex.pc, ex.data}) begin n_fail++; $display("FAIL ackredir_instr: got %h/%h, expected %h/%h", opc, oi, ex.pc, ex.data); end
    endtask

    task automatic test_misalign();
        logic [31:0] a;
        mem_ack(1, 32'h7777_8888, a);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0100_0042;
        #1;
        n_tests++; if ({misalign_err, next_pc} !== {1'b1, TRAP_VEC}) begin n_fail++; $display("FAIL misalign_pulse: got err=%b next_pc=%h, expected 1/%h", misalign_err, next_pc, TRAP_VEC); end
        tick();
        redirect_valid = 1'b0;
        #1;
        n_tests++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL misalign_len: got %b, expected 0", misalign_err); end
        n_tests++; if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, TRAP_VEC}) begin n_fail++; $display("FAIL misalign_addr: got valid=%b req=%b addr=%h, expected 0/1/%h", instr_valid, imem_req, imem_addr, TRAP_VEC); end
    endtask

    task automatic test_timeout();
        logic [31:0] a, oi, opc, tpc;
        exp_t ex;
        int w, first;
        sb.push_back('{pc: TRAP_VEC, data: 32'h9999_0000});
        mem_ack(1, 32'h9999_0000, a);
        get_issue(1'b0, oi, opc, ex, w);
        n_tests++; if ({opc, oi} !== {ex.pc, ex.data}) begin n_fail++; $display("FAIL trapvec_instr: got %h/%h, expected %h/%h", opc, oi, ex.pc, ex.data); end
        first = 0;
        tpc   = '0;
        for (int k = 1; k <= 20; k++) begin
            if (timeout_err) begin
                first = k;
                tpc   = next_pc;
                break;
            end
            tick();
        end
        n_tests++; if (first !== ACK_TIMEOUT) begin n_fail++; $display("FAIL timeout_cycle: got %0d, expected %0d", first, ACK_TIMEOUT); end
        n_tests++; if (tpc !== TRAP_VEC) begin n_fail++; $display("FAIL timeout_next_pc: got %h, expected %h", tpc, TRAP_VEC); end
        tick();
        n_tests++; if ({timeout_err, imem_req, imem_addr} !== {1'b0, 1'b1, TRAP_VEC}) begin n_fail++; $display("FAIL timeout_refetch: got err=%b req=%b addr=%h, expected 0/1/%h", timeout_err, imem_req, imem_addr, TRAP_VEC); end
    endtask

    task automatic test_halt();
        logic [31:0] a, oi, opc;
        exp_t ex;
        int w;
        sb.push_back('{pc: TRAP_VEC, data: 32'hAAAA_0001});
        mem_ack(1, 32'hAAAA_0001, a);
        get_issue(1'b1, oi, opc, ex, w);
        n_tests++; if ({opc, oi} !== {ex.pc, ex.data}) begin n_fail++; $display("FAIL halt_instr: got %h/%h, expected %h/%h", opc, oi, ex.pc, ex.data); end
        n_tests++; if ({halted, imem_req} !== 2'b10) begin n_fail++; $display("FAIL halt_enter: got halted=%b req=%b, expected 1/0", halted, imem_req); end
        repeat (3) tick();
        n_tests++; if ({halted, imem_req, next_pc} !== {2'b10, TRAP_VEC + 32'd4}) begin n_fail++; $display("FAIL halt_hold: got halted=%b req=%b next_pc=%h, expected 1/0/%h", halted, imem_req, next_pc, TRAP_VEC + 32'd4); end
        halt_req = 1'b0;
        tick();
        n_tests++; if ({halted, imem_req, imem_addr} !== {2'b01, TRAP_VEC + 32'd4}) begin n_fail++; $display("FAIL halt_resume: got halted=%b req=%b addr=%h, expected 0/1/%h", halted, imem_req, imem_addr, TRAP_VEC + 32'd4); end
        sb.push_back('{pc: TRAP_VEC + 32'd4, data: 32'hAAAA_0002});
        mem_ack(1, 32'hAAAA_0002, a);
        get_issue(1'b1, oi, opc, ex, w);
        n_tests++; if ({opc, oi} !== {ex.pc, ex.data}) begin n_fail++; $display("FAIL halt2_instr: got %h/%h, expected %h/%h", opc, oi, ex.pc, ex.data); end
        trap = 1'b1;
        #1;
        n_tests++; if (next_pc !== TRAP_VEC) begin n_fail++; $display("FAIL halt_trap_pc: got %h, expected %h", next_pc, TRAP_VEC); end
        tick();
        trap = 1'b0;
        n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_trap_stay: got %b, expected 1", halted); end
        halt_req = 1'b0;
        tick();
        n_tests++; if ({imem_req, imem_addr} !== {1'b1, TRAP_VEC}) begin n_fail++; $display("FAIL halt_trap_resume: got req=%b addr=%h, expected 1/%h", imem_req, imem_addr, TRAP_VEC); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, oi, opc;
        exp_t ex;
        int w;
        reset = 1'b1;
        #1;
        n_tests++; if ({imem_req, instr_valid, halted, next_pc} !== {3'b000, RESET_PC}) begin n_fail++; $display("FAIL midrst_ctrl: got req=%b valid=%b halted=%b next_pc=%h, expected 0/0/0/%h", imem_req, instr_valid, halted, next_pc, RESET_PC); end
        n_tests++; if ({instr, instr_pc} !== 64'd0) begin n_fail++; $display("FAIL midrst_instr: got %h/%h, expected 0/0", instr, instr_pc); end
        tick();
        reset      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD1_BAD1;
        tick();
        imem_ack = 1'b0;
        n_tests++; if ({instr_valid, imem_req, imem_addr} !== {2'b01, RESET_PC}) begin n_fail++; $display("FAIL midrst_idle_ack: got valid=%b req=%b addr=%h, expected 0/1/%h", instr_valid, imem_req, imem_addr, RESET_PC); end
        sb.push_back('{pc: RESET_PC, data: 32'hBBBB_0000});
        mem_ack(2, 32'hBBBB_0000, a);
        get_issue(1'b0, oi, opc, ex, w);
        n_tests++; if ({opc, oi} !== {ex.pc, ex.data}) begin n_fail++; $display("FAIL midrst_instr2: got %h/%h, expected %h/%h", opc, oi, ex.pc, ex.data); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, oi, opc, exp_a;
        exp_t ex;
        int w, c0;
        c0 = cyc;
        for (int k = 0; k < 3; k++) begin
            exp_a = RESET_PC + 32'(4 * (k + 1));
            sb.push_back('{pc: exp_a, data: 32'hCCCC_0000 ^ exp_a});
            mem_ack(0, 32'hCCCC_0000 ^ exp_a, a);
            get_issue(1'b0, oi, opc, ex, w);
            n_tests++; if ({opc, oi} !== {ex.pc, ex.data}) begin n_fail++; $display("FAIL b2b_instr%0d: got %h/%h, expected %h/%h", k, opc, oi, ex.pc, ex.data); end
        end
        n_tests++; if (cyc - c0 !== 6) begin n_fail++; $display("FAIL b2b_rate: got %0d cycles for 3 instrs, expected 6", cyc - c0); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect_issue();
        test_redirect_fetch();
        test_misalign();
        test_timeout();
        test_halt();
        test_reset_mid();
        test_back_to_back();
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d entries, expected 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
